scroll_controller: RTL
======================

// Module: scroll_controller
// PURPOSE
//  Sequencer for the tile-scroll offset counter in the Piano Tiles datapath.
//  Paces scrolling with a frame-tick divider and drives offset_increase / edge_go
//  to the offset counter. Fires a one-cycle row shift at each row boundary.
//  Ramps speed level every ROWS_PER_LEVEL rows; ends the game on a missed bottom tile or wrong key.
// PARAMETERS
//  BASE_PERIOD    24'd833333  clk cycles per scroll step at level 0 (60 Hz @ 50 MHz)
//  PERIOD_STEP    24'd83333   period reduction per speed level
//  ROW_HEIGHT     6'd40       offset steps per row; offset counts 0..ROW_HEIGHT-1
//  ROWS_PER_LEVEL 8'd8        cleared rows per speed-level increment
//  MAX_LEVEL      4'd7        saturating maximum speed level
// PORTS
//  clk            in   1   system clock
//  reset          in   1   synchronous, active-high reset
//  start          in   1   single-cycle pulse: begin a new game (from IDLE or OVER)
//  pause          in   1   single-cycle pulse: toggle RUN <-> PAUSED
//  key_miss       in   1   single-cycle pulse: wrong key pressed
//  bottom_cleared in   1   level: bottom tile of the current row has been hit
//  offset         in   6   current value from the offset counter
//  offset_increase out 1   one-cycle pulse: advance offset by 1
//  edge_go        out  1   one-cycle pulse: clear offset to 0 (row wrap)
//  row_shift      out  1   one-cycle pulse: tile memory shifts rows down by one
//  state          out  3   IDLE=0 RUN=1 SHIFT=2 PAUSED=3 OVER=4
//  level          out  4   current speed level
//  rows_cleared   out 16   score; saturates at 16'hFFFF
//  game_over      out  1   high while in OVER
// BEHAVIOUR
//  Reset: state=IDLE; tick_cnt=0; all pulses=0; level=0; rows_cleared=0; game_over=0.
//   reset wins over every other input, in any state.
//  Period: BASE_PERIOD - level*PERIOD_STEP, floored at PERIOD_STEP.
//   Computed in 24 bits; no underflow is allowed.
//  IDLE: outputs quiescent. start -> RUN; tick_cnt, level, rows_cleared cleared.
//  RUN: tick_cnt increments each cycle. tick fires when tick_cnt==period-1; tick_cnt then returns to 0.
//   On tick with offset <  ROW_HEIGHT-1: offset_increase=1 for 1 cycle; stay in RUN.
//   On tick with offset == ROW_HEIGHT-1: edge_go=1 for 1 cycle; go to SHIFT.
//   key_miss -> OVER, with no pulse that cycle.
//   pause -> PAUSED; tick_cnt is held.
//  SHIFT (exactly 1 cycle): row_shift=1.
//   If !bottom_cleared: go to OVER.
//   Otherwise: rows_cleared += 1 (saturating); go to RUN.
//   If the new rows_cleared is a multiple of ROWS_PER_LEVEL and level<MAX_LEVEL: level += 1.
//   pause and key_miss are ignored during SHIFT.
//  PAUSED: no pulses; tick_cnt frozen. pause -> RUN, resuming from the held tick_cnt.
//   start is ignored. key_miss is ignored.
//  OVER: game_over=1; level and rows_cleared hold. start -> RUN with fresh clears (same as from IDLE).
//  Priority in RUN, same cycle: key_miss > pause > tick.
//  Pulse rules:
//   offset_increase, edge_go, row_shift are registered and mutually exclusive.
//   Each is never high for 2 consecutive cycles.
//  Latency: the pulse is high in the cycle after tick_cnt reaches period-1. offset is sampled in that same cycle.
//  A level change takes effect on the next period compare. tick_cnt is not reset on a level change.
//  Unused state encodings fall to IDLE.
// TESTING
//  (Benches override BASE_PERIOD=10, PERIOD_STEP=2, ROW_HEIGHT=4, ROWS_PER_LEVEL=2.)
//  1 reset, start, offset model tracking pulses:
//    -> offset_increase every 10 clks, 3 times; then edge_go; then row_shift the next cycle.
//  2 bottom_cleared=1 for 2 rows:
//    -> rows_cleared=2, level=1; next steps 8 clks apart. At level 4 the period floors at 2.
//  3 bottom_cleared=0 at a row wrap:
//    -> SHIFT then OVER, game_over=1, rows_cleared unchanged. start -> RUN, score=0.
//  4 pause at tick_cnt=5, wait 50 clks, pause:
//    -> no pulses while paused; next offset_increase 4 clks after resume.
//  5 key_miss and tick in the same cycle:
//    -> OVER with no offset_increase. reset mid-RUN -> IDLE next cycle, all outputs 0.

Source files
------------

// File: rtl/scroll_controller.sv
// scroll_controller: paces tile scrolling, fires row shifts and ramps speed level until a miss ends the game
module scroll_controller #(
  parameter logic [23:0] BASE_PERIOD    = 24'd833333,
  parameter logic [23:0] PERIOD_STEP    = 24'd83333,
  parameter logic [5:0]  ROW_HEIGHT     = 6'd40,
  parameter logic [7:0]  ROWS_PER_LEVEL = 8'd8,
  parameter logic [3:0]  MAX_LEVEL      = 4'd7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        pause,
  input  logic        key_miss,
  input  logic        bottom_cleared,
  input  logic [5:0]  offset,
  output logic        offset_increase,
  output logic        edge_go,
  output logic        row_shift,
  output logic [2:0]  state,
  output logic [3:0]  level,
  output logic [15:0] rows_cleared,
  output logic        game_over
);
  typedef enum logic [2:0] {IDLE, RUN, SHIFT, PAUSED, OVER} state_t;
  state_t cur, nxt;
  logic [23:0] tick_cnt, tick_nxt, prod, period;
  logic [15:0] rows_nxt;
  logic [7:0]  row_in_level, row_in_level_nxt;
  logic [3:0]  level_nxt;
  logic        inc_d, edge_d, shift_d, tick;
  assign state = cur;
  assign game_over = cur == OVER;
  assign prod = 24'(level) * PERIOD_STEP;
  assign period = (BASE_PERIOD >= prod + PERIOD_STEP) ? BASE_PERIOD - prod : PERIOD_STEP;
  assign tick = tick_cnt == period - 24'd1;
  always_comb begin
    nxt = cur;
    tick_nxt = tick_cnt;
    inc_d = 1'b0;
    edge_d = 1'b0;
    shift_d = 1'b0;
    level_nxt = level;
    rows_nxt = rows_cleared;
    row_in_level_nxt = row_in_level;
    case (cur)
      IDLE, OVER: if (start) begin
        nxt = RUN;
        tick_nxt = '0;
        level_nxt = '0;
        rows_nxt = '0;
        row_in_level_nxt = '0;
      end
      RUN: begin
        if (key_miss) nxt = OVER;
        else if (pause) nxt = PAUSED;
        else if (tick) begin
          tick_nxt = '0;
          edge_d = offset >= ROW_HEIGHT - 6'd1;
          inc_d = offset < ROW_HEIGHT - 6'd1;
          nxt = edge_d ? SHIFT : RUN;
        end else tick_nxt = tick_cnt + 24'd1;
      end
      SHIFT: begin
        shift_d = 1'b1;
        nxt = bottom_cleared ? RUN : OVER;
        // a saturated score stops counting rows, so levels stop ramping with it
        if (bottom_cleared && rows_cleared != 16'hFFFF) begin
          rows_nxt = rows_cleared + 16'd1;
          row_in_level_nxt = (row_in_level == ROWS_PER_LEVEL - 8'd1) ? 8'd0 : row_in_level + 8'd1;
          level_nxt = (row_in_level == ROWS_PER_LEVEL - 8'd1 && level < MAX_LEVEL) ? level + 4'd1 : level;
        end
      end
      PAUSED: nxt = pause ? RUN : PAUSED;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= IDLE;
      tick_cnt <= '0;
      offset_increase <= 1'b0;
      edge_go <= 1'b0;
      row_shift <= 1'b0;
      level <= '0;
      rows_cleared <= '0;
      row_in_level <= '0;
    end else begin
      cur <= nxt;
      tick_cnt <= tick_nxt;
      offset_increase <= inc_d;
      edge_go <= edge_d;
      row_shift <= shift_d;
      level <= level_nxt;
      rows_cleared <= rows_nxt;
      row_in_level <= row_in_level_nxt;
    end
  end
endmodule
